cp0_unit: RTL and testbench

//  Coprocessor-0 state for the single-cycle MIPS core: Status, Cause, EPC, Count and Compare.

---
 rtl/cp0_pkg.sv | 49 ++++
 rtl/cp0_if.sv | 36 +++
 rtl/cp0_int_sync.sv | 30 +++
 rtl/cp0_unit.sv | 159 +++++++++++++++
 tb/tb_cp0_unit.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause bit positions,
// exception codes and the exception-priority helper.
package cp0_pkg;

    // CP0 register numbers served by MTC0/MFC0
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // Status bit positions
    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;

    // Cause bit positions
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_TI     = 30;

    // Number of hardware interrupt lines in Cause.IP[7:2]
    localparam int HW_IP_BITS = 6;

    typedef enum logic [4:0] {
        EXC_INT = 5'd0,
        EXC_SYS = 5'd8,
        EXC_RI  = 5'd10,
        EXC_OV  = 5'd12
    } exc_code_e;

    // Architecturally visible Status fields
    typedef struct packed {
        logic [7:0] im;
        logic       exl;
        logic       ie;
    } status_t;

    // Priority RI > Ov > Sys > Int; Int is the fallback when no sync flag is set
    function automatic exc_code_e exc_winner(input logic ri, input logic ov, input logic sys);
        exc_code_e code;
        if (ri)       code = EXC_RI;
        else if (ov)  code = EXC_OV;
        else if (sys) code = EXC_SYS;
        else          code = EXC_INT;
        return code;
    endfunction

endpackage

// File: rtl/cp0_if.sv
// Core-to-CP0 bus: instruction qualifiers, MTC0/MFC0 port, exception flags,
// external interrupt lines and the exception outputs toward the PC stage.
interface cp0_if #(
    parameter int EXT_INT_BITS = 6
) ();

    logic [31:0]             pc;
    logic                    IsCOP0;
    logic                    IsEret;
    logic                    mtc0_we;
    logic [4:0]              cp0_addr;
    logic [31:0]             cp0_wdata;
    logic [31:0]             cp0_rdata;
    logic [EXT_INT_BITS-1:0] ext_int;
    logic                    exc_sys;
    logic                    exc_ri;
    logic                    exc_ov;
    logic                    HasExp;
    logic [31:0]             epc;
    logic                    kill;

    // Core side
    modport master (
        output pc, IsCOP0, IsEret, mtc0_we, cp0_addr, cp0_wdata,
        output ext_int, exc_sys, exc_ri, exc_ov,
        input  cp0_rdata, HasExp, epc, kill
    );

    // CP0 side
    modport slave (
        input  pc, IsCOP0, IsEret, mtc0_we, cp0_addr, cp0_wdata,
        input  ext_int, exc_sys, exc_ri, exc_ov,
        output cp0_rdata, HasExp, epc, kill
    );

endinterface

// File: rtl/cp0_int_sync.sv
// Per-line flop chain bringing asynchronous interrupt levels into the clk
// domain; a change on async_i shows on sync_o after STAGES rising edges.
module cp0_int_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;

    // Shift each line one stage per clock; stage 0 samples the raw input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every stage is reset so no request captured before reset can surface after it.
            chain_q <= '0;
        end else begin
            chain_q[0] <= async_i;
            for (int s = 1; s < STAGES; s++) begin
                chain_q[s] <= chain_q[s-1];
            end
        end
    end

    assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the single-cycle MIPS core: Status, Cause, EPC, Count,
// Compare and the timer flag. HasExp/kill are combinational from registered
// state and this cycle's exception flags so the PC stage can sample them at
// the falling edge.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter int EXT_INT_BITS = 6,
    parameter int SYNC_STAGES  = 2
) (
    input  logic  clk,
    input  logic  rst,
    cp0_if.slave  bus
);

    // Architectural state
    status_t     status_q, status_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    exc_code_e   exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    // Interrupt and exception decode
    logic [EXT_INT_BITS-1:0] ext_sync;
    logic [HW_IP_BITS-1:0]   ext_hw;
    logic [7:0]              ip;
    logic                    int_req;
    logic                    sync_exc;
    logic                    has_exp;
    exc_code_e               exc_code;
    logic                    cp0_wr;
    logic                    eret;
    logic [31:0]             status_word;
    logic [31:0]             cause_word;

    cp0_int_sync #(
        .WIDTH  (EXT_INT_BITS),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (bus.ext_int),
        .sync_o  (ext_sync)
    );

    // Widen the synced lines to the six hardware IP bits; unused lines read 0
    always_comb begin
        // NOTE: a default before the partial overwrite keeps every bit assigned on every pass, so no latch.
        ext_hw                   = '0;
        ext_hw[EXT_INT_BITS-1:0] = ext_sync;
    end

    // Pending bits: IP[7] also carries the timer, IP[1:0] are the software bits
    assign ip = {ext_hw[5] | ti_q, ext_hw[4:0], ip_sw_q};

    // Exception request; no dependence on cp0_wdata keeps this path short
    assign int_req  = status_q.ie & ~status_q.exl & (|(ip & status_q.im));
    assign sync_exc = ~status_q.exl & (bus.exc_ri | bus.exc_ov | bus.exc_sys);
    assign has_exp  = sync_exc | int_req;
    assign exc_code = exc_winner(bus.exc_ri, bus.exc_ov, bus.exc_sys);

    // A taken exception discards any same-cycle MTC0 or ERET
    assign cp0_wr = bus.IsCOP0 & bus.mtc0_we & ~has_exp;
    assign eret   = bus.IsCOP0 & bus.IsEret  & ~has_exp;

    assign bus.HasExp = has_exp;
    assign bus.kill   = has_exp;
    assign bus.epc    = epc_q;

    // Register images as seen by MFC0
    always_comb begin
        status_word                           = '0;
        status_word[STATUS_IE]                = status_q.ie;
        status_word[STATUS_EXL]               = status_q.exl;
        status_word[STATUS_IM_LO +: 8]        = status_q.im;
        cause_word                            = '0;
        cause_word[CAUSE_EXC_LO +: 5]         = exccode_q;
        cause_word[CAUSE_IP_LO +: 8]          = ip;
        cause_word[CAUSE_TI]                  = ti_q;
    end

    // MFC0 read mux; unmapped register numbers read 0
    always_comb begin
        case (bus.cp0_addr)
            REG_COUNT:   bus.cp0_rdata = count_q;
            REG_COMPARE: bus.cp0_rdata = compare_q;
            REG_STATUS:  bus.cp0_rdata = status_word;
            REG_CAUSE:   bus.cp0_rdata = cause_word;
            REG_EPC:     bus.cp0_rdata = epc_q;
            default:     bus.cp0_rdata = '0;
        endcase
    end

    // Next-state: exception entry, else MTC0 writes and ERET; Count always advances unless loaded
    always_comb begin
        status_d  = status_q;
        ip_sw_d   = ip_sw_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        compare_d = compare_q;
        count_d   = count_q + 32'd1;

        if (has_exp) begin
            epc_d        = bus.pc;
            status_d.exl = 1'b1;
            exccode_d    = exc_code;
        end else begin
            if (cp0_wr) begin
                case (bus.cp0_addr)
                    REG_COUNT:   count_d   = bus.cp0_wdata;
                    REG_COMPARE: compare_d = bus.cp0_wdata;
                    REG_STATUS: begin
                        status_d.ie  = bus.cp0_wdata[STATUS_IE];
                        status_d.exl = bus.cp0_wdata[STATUS_EXL];
                        status_d.im  = bus.cp0_wdata[STATUS_IM_LO +: 8];
                    end
                    REG_CAUSE:   ip_sw_d   = bus.cp0_wdata[CAUSE_IP_LO +: 2];
                    REG_EPC:     epc_d     = bus.cp0_wdata;
                    default:     ;
                endcase
            end
            if (eret) begin
                status_d.exl = 1'b0;
            end
        end

        // Timer match on the post-update Count; a Compare write clears and wins
        if (cp0_wr && (bus.cp0_addr == REG_COMPARE)) begin
            ti_d = 1'b0;
        end else begin
            ti_d = ti_q | (count_d == compare_q);
        end
    end

    // CP0 register bank with asynchronous reset to all zeros
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q  <= '0;
            ip_sw_q   <= '0;
            exccode_q <= EXC_INT;
            epc_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values, independent of statement order.
            status_q  <= status_d;
            ip_sw_q   <= ip_sw_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios followed by random
// traffic, all compared against a register-level reference model.
module tb_cp0_unit;

    localparam int EXT_BITS = 6;
    localparam int SYNC     = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cp0_if #(.EXT_INT_BITS(EXT_BITS)) bus ();

    cp0_unit #(
        .EXT_INT_BITS (EXT_BITS),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic        m_ie, m_exl;
    logic [7:0]  m_im;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_count, m_compare;
    logic        m_ti;
    logic [EXT_BITS-1:0] hist[$];   // ext_int samples, newest first

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_im = 0; m_ipsw = 0; m_code = 0;
        m_epc = 0; m_count = 0; m_compare = 0; m_ti = 0;
        hist.delete();
    endtask

    // Interrupt lines become visible SYNC clock edges after they are sampled
    function automatic logic [7:0] m_ip();
        logic [5:0] hw;
        hw = '0;
        if (hist.size() >= SYNC) hw = 6'(hist[SYNC-1]);
        return {hw[5] | m_ti, hw[4:0], m_ipsw};
    endfunction

    function automatic logic m_has_exp();
        logic sync_e, int_e;
        sync_e = !m_exl && (bus.exc_ri || bus.exc_ov || bus.exc_sys);
        int_e  = m_ie && !m_exl && ((m_ip() & m_im) != 8'h0);
        return sync_e || int_e;
    endfunction

    function automatic logic [4:0] m_winner();
        if (bus.exc_ri)  return 5'd10;
        if (bus.exc_ov)  return 5'd12;
        if (bus.exc_sys) return 5'd8;
        return 5'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [31:0] v;
        case (a)
            5'd9:  v = m_count;
            5'd11: v = m_compare;
            5'd12: v = (32'(m_im) << 8) + (32'(m_exl) << 1) + 32'(m_ie);
            5'd13: v = (32'(m_ti) << 30) + (32'(m_ip()) << 8) + (32'(m_code) << 2);
            5'd14: v = m_epc;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Advance the model across one rising edge using the inputs held this cycle
    task automatic model_tick();
        logic        exp_now, wr;
        logic [31:0] new_count;
        exp_now   = m_has_exp();
        wr        = bus.IsCOP0 && bus.mtc0_we && !exp_now;
        new_count = m_count + 32'd1;
        if (wr && bus.cp0_addr == 5'd9) new_count = bus.cp0_wdata;
        if (wr && bus.cp0_addr == 5'd11) m_ti = 1'b0;
        else if (new_count == m_compare) m_ti = 1'b1;
        if (exp_now) begin
            m_epc  = bus.pc;
            m_exl  = 1'b1;
            m_code = m_winner();
        end else begin
            if (wr) begin
                case (bus.cp0_addr)
                    5'd11: m_compare = bus.cp0_wdata;
                    5'd12: begin
                        m_ie  = bus.cp0_wdata[0];
                        m_exl = bus.cp0_wdata[1];
                        m_im  = bus.cp0_wdata[15:8];
                    end
                    5'd13: m_ipsw = bus.cp0_wdata[9:8];
                    5'd14: m_epc  = bus.cp0_wdata;
                    default: ;
                endcase
            end
            if (bus.IsCOP0 && bus.IsEret) m_exl = 1'b0;
        end
        m_count = new_count;
        hist.push_front(bus.ext_int);
        if (hist.size() > SYNC) void'(hist.pop_back());
    endtask

    task automatic model_compare();
        check("has_exp", 32'(bus.HasExp), 32'(m_has_exp()));
        check("kill", 32'(bus.kill), 32'(m_has_exp()));
        check("epc", bus.epc, m_epc);
        check($sformatf("rdata_r%0d", bus.cp0_addr), bus.cp0_rdata, m_read(bus.cp0_addr));
    endtask

    // Falling edge: outputs have settled for this cycle's inputs
    task automatic half();
        @(negedge clk);
        model_compare();
    endtask

    // Rising edge, then move off the edge before the next inputs are driven
    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle(input logic [4:0] a);
        bus.pc = 32'h0; bus.IsCOP0 = 0; bus.IsEret = 0; bus.mtc0_we = 0;
        bus.cp0_addr = a; bus.cp0_wdata = 32'h0;
        bus.exc_sys = 0; bus.exc_ri = 0; bus.exc_ov = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(a);
        bus.IsCOP0 = 1; bus.mtc0_we = 1; bus.cp0_wdata = d;
        half();
        tick();
    endtask

    task automatic do_eret();
        idle(5'd0);
        bus.IsCOP0 = 1; bus.IsEret = 1;
        half();
        check("eret_no_exc", 32'(bus.HasExp), 32'h0);
        tick();
    endtask

    // Read a register in an otherwise idle cycle and compare with a fixed value
    task automatic read_expect(input string tag, input logic [4:0] a, input logic [31:0] exp);
        idle(a);
        half();
        check(tag, bus.cp0_rdata, exp);
        tick();
    endtask

    initial begin
        logic [4:0] addrs[6];
        addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};

        rst = 1'b1;
        idle(5'd0);
        bus.ext_int = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Reset state and Status write/readback
        idle(5'd12);
        half();
        check("rst_status", bus.cp0_rdata, 32'h0);
        check("rst_hasexp", 32'(bus.HasExp), 32'h0);
        check("rst_epc", bus.epc, 32'h0);
        tick();
        read_expect("rst_cause", 5'd13, 32'h0);
        mtc0(5'd12, 32'h0000_FF01);
        read_expect("status_rb", 5'd12, 32'h0000_FF01);
        read_expect("cause_zero", 5'd13, 32'h0);

        // Overflow exception, then ERET
        idle(5'd0);
        bus.exc_ov = 1; bus.pc = 32'h0000_0040;
        half();
        check("ov_hasexp", 32'(bus.HasExp), 32'h1);
        check("ov_kill", 32'(bus.kill), 32'h1);
        tick();
        idle(5'd14);
        half();
        check("ov_epc_out", bus.epc, 32'h0000_0040);
        check("ov_epc_rd", bus.cp0_rdata, 32'h0000_0040);
        tick();
        read_expect("ov_status", 5'd12, 32'h0000_FF03);
        read_expect("ov_cause", 5'd13, 32'h0000_0030);
        do_eret();
        read_expect("eret_status", 5'd12, 32'h0000_FF01);

        // External interrupt through the synchronizer
        mtc0(5'd12, 32'h0000_0401);
        idle(5'd13);
        bus.ext_int = 6'h01;
        for (int i = 0; i <= SYNC; i++) begin
            half();
            check($sformatf("int_lat%0d", i), 32'(bus.HasExp), (i == SYNC) ? 32'h1 : 32'h0);
            tick();
        end
        idle(5'd13);
        half();
        check("int_masked_exl", 32'(bus.HasExp), 32'h0);
        check("int_cause", bus.cp0_rdata, 32'h0000_0400);
        tick();
        bus.ext_int = '0;
        for (int i = 0; i < SYNC + 1; i++) begin
            idle(5'd12);
            half();
            tick();
        end
        do_eret();

        // Timer: Compare=5, Count=0
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        for (int i = 0; i <= 5; i++) begin
            idle(5'd9);
            half();
            check($sformatf("tmr_count%0d", i), bus.cp0_rdata, 32'(i));
            check($sformatf("tmr_exc%0d", i), 32'(bus.HasExp), (i == 5) ? 32'h1 : 32'h0);
            tick();
        end
        read_expect("tmr_cause_ti", 5'd13, 32'h4000_8000);
        mtc0(5'd11, 32'h0000_0100);
        read_expect("tmr_ti_clear", 5'd13, 32'h0);
        mtc0(5'd9, 32'hFFFF_FFFF);
        read_expect("cnt_max", 5'd9, 32'hFFFF_FFFF);
        read_expect("cnt_wrap", 5'd9, 32'h0);
        do_eret();

        // Priority with a pending interrupt and a discarded MTC0 to EPC
        mtc0(5'd12, 32'h0000_FF00);
        mtc0(5'd13, 32'h0000_0100);
        mtc0(5'd12, 32'h0000_FF01);
        idle(5'd14);
        bus.exc_ri = 1; bus.exc_sys = 1; bus.pc = 32'h0000_1234;
        bus.IsCOP0 = 1; bus.mtc0_we = 1; bus.cp0_wdata = 32'hDEAD_BEEF;
        half();
        check("prio_hasexp", 32'(bus.HasExp), 32'h1);
        tick();
        read_expect("prio_epc", 5'd14, 32'h0000_1234);
        read_expect("prio_cause", 5'd13, 32'h0000_0128);

        // Asynchronous reset in the middle of the handler
        idle(5'd12);
        bus.ext_int = 6'h3F;
        #2;
        rst = 1'b1;
        #1;
        check("arst_hasexp", 32'(bus.HasExp), 32'h0);
        check("arst_kill", 32'(bus.kill), 32'h0);
        check("arst_epc", bus.epc, 32'h0);
        foreach (addrs[k]) begin
            bus.cp0_addr = addrs[k];
            #1;
            check($sformatf("arst_r%0d", addrs[k]), bus.cp0_rdata, 32'h0);
        end
        bus.ext_int = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int kind;
            logic [4:0] a;
            idle(5'd0);
            bus.pc      = $urandom;
            bus.exc_ri  = ($urandom_range(0, 19) == 0);
            bus.exc_ov  = ($urandom_range(0, 19) == 0);
            bus.exc_sys = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) bus.ext_int = EXT_BITS'($urandom & $urandom);
            kind = $urandom_range(0, 5);
            a = (kind < 5) ? addrs[kind] : 5'($urandom);
            if ($urandom_range(0, 5) == 0) a = 5'($urandom);
            bus.cp0_addr = a;
            kind = $urandom_range(0, 9);
            if (kind < 3) begin
                bus.IsCOP0 = 1; bus.mtc0_we = 1;
                case (a)
                    5'd12: bus.cp0_wdata = {16'($urandom), 8'($urandom), 6'($urandom),
                                            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0)};
                    5'd11: bus.cp0_wdata = m_count + 32'($urandom_range(1, 20));
                    5'd9:  bus.cp0_wdata = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFE : $urandom;
                    default: bus.cp0_wdata = $urandom;
                endcase
            end else if (kind == 3) begin
                bus.IsCOP0 = 1; bus.IsEret = 1;
            end else if (kind == 4) begin
                bus.IsCOP0 = 1;
                bus.cp0_wdata = $urandom;
            end
            half();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
